// File: rtl/stepper_pulse_if.sv
// Controller-to-stepper-driver move interface: move request/abort in,
// STEP/DIR drive and ready status out.
interface stepper_pulse_if;
  logic [7:0] steps1;
  logic [7:0] steps2;
  logic       dir1;
  logic       dir2;
  logic       dataReady;
  logic       halt;
  logic       stepperReady;
  logic       step1_out;
  logic       step2_out;
  logic       dir1_out;
  logic       dir2_out;
  logic       busy;

  modport master (
    output steps1, steps2, dir1, dir2, dataReady, halt,
    input  stepperReady, step1_out, step2_out, dir1_out, dir2_out, busy
  );

  modport slave (
    input  steps1, steps2, dir1, dir2, dataReady, halt,
    output stepperReady, step1_out, step2_out, dir1_out, dir2_out, busy
  );
endinterface

// File: rtl/stepper_pulse_driver.sv
// Two-axis STEP/DIR pulse generator: loads a move on a dataReady rising edge,
// holds DIR for a setup time, then emits coincident timed STEP pulses on both axes.
module stepper_pulse_driver #(
  parameter int DIR_SETUP_CYCLES   = 10,
  parameter int PULSE_HIGH_CYCLES  = 50,
  parameter int STEP_PERIOD_CYCLES = 5000,
  parameter int CNT_W              = 16
) (
  input logic             clk,
  input logic             reset_n,
  stepper_pulse_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(PULSE_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [7:0]       r_rem1;
  logic [7:0]       r_rem2;
  logic             r_dr_prev;
  logic             r_step1;
  logic             r_step2;
  logic             r_dir1;
  logic             r_dir2;
  logic             r_ready;
  logic             w_load;
  logic             w_last;
  logic             w_dec;
  logic             w_abort;
  logic             w_any_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_last    = 1'b0;
    w_any_rem = (r_rem1 | r_rem2) != 8'd0;
    w_abort   = (r_state != S_IDLE) && bus.halt;
    case (r_state)
      S_IDLE: begin
        if (bus.dataReady && !r_dr_prev && !bus.halt) begin
          w_load = 1'b1;
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_last = (r_timer == SETUP_LAST);
        if (w_last) w_next = w_any_rem ? S_HIGH : S_IDLE;
      end
      S_HIGH: begin
        w_last = (r_timer == HIGH_LAST);
        if (w_last) w_next = S_LOW;
      end
      S_LOW: begin
        // rem was already decremented at the end of HIGH, so this sees the post-pulse count
        w_last = (r_timer == LOW_LAST);
        if (w_last) w_next = w_any_rem ? S_HIGH : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
    w_dec = (r_state == S_HIGH) && w_last && !w_abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_rem1    <= 8'd0;
      r_rem2    <= 8'd0;
      r_dr_prev <= 1'b0;
      r_step1   <= 1'b0;
      r_step2   <= 1'b0;
      r_dir1    <= 1'b0;
      r_dir2    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_dr_prev <= bus.dataReady;
      r_timer   <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_timer + CNT_W'(1);
      if (w_abort) begin
        r_rem1 <= 8'd0;
        r_rem2 <= 8'd0;
      end else if (w_load) begin
        r_rem1 <= bus.steps1;
        r_rem2 <= bus.steps2;
        r_dir1 <= bus.dir1;
        r_dir2 <= bus.dir2;
      end else if (w_dec) begin
        if (r_rem1 != 8'd0) r_rem1 <= r_rem1 - 8'd1;
        if (r_rem2 != 8'd0) r_rem2 <= r_rem2 - 8'd1;
      end
      // STEP registered from next state so it is high exactly while the FSM sits in HIGH
      r_step1 <= (w_next == S_HIGH) && (r_rem1 != 8'd0);
      r_step2 <= (w_next == S_HIGH) && (r_rem2 != 8'd0);
      r_ready <= (w_next == S_IDLE);
    end
  end

  assign bus.stepperReady = r_ready;
  assign bus.busy         = ~r_ready;
  assign bus.step1_out    = r_step1;
  assign bus.step2_out    = r_step2;
  assign bus.dir1_out     = r_dir1;
  assign bus.dir2_out     = r_dir2;

endmodule

// File: tb/tb_stepper_pulse_driver.sv
// Directed bench for stepper_pulse_driver with short timing parameters
// (setup 3, high 2, period 5) and hand-computed expectations.
module tb_stepper_pulse_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   c1 = 0;
  int   c2 = 0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;

  stepper_pulse_if bus_if();

  stepper_pulse_driver #(
    .DIR_SETUP_CYCLES   (3),
    .PULSE_HIGH_CYCLES  (2),
    .STEP_PERIOD_CYCLES (5),
    .CNT_W              (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // rising-edge pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus_if.step1_out && !p1) c1 <= c1 + 1;
    if (bus_if.step2_out && !p2) c2 <= c2 + 1;
    p1 <= bus_if.step1_out;
    p2 <= bus_if.step2_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [7:0] s1, input logic [7:0] s2,
                            input logic d1, input logic d2, input bit hold);
    @(negedge clk);
    bus_if.steps1    = s1;
    bus_if.steps2    = s2;
    bus_if.dir1      = d1;
    bus_if.dir2      = d2;
    bus_if.dataReady = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus_if.dataReady = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int low);
    bit done;
    done = 1'b0;
    low  = 0;
    while (!done) begin
      @(negedge clk);
      if (bus_if.stepperReady) done = 1'b1;
      else begin
        low++;
        if (low > limit) begin
          chk("ready_timeout", low, limit);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int          low;
    int          b1;
    int          b2;
    logic [18:0] tr1;
    logic [18:0] tr2;
    logic [18:0] trr;

    bus_if.steps1    = 8'd0;
    bus_if.steps2    = 8'd0;
    bus_if.dir1      = 1'b0;
    bus_if.dir2      = 1'b0;
    bus_if.dataReady = 1'b0;
    bus_if.halt      = 1'b0;

    #12;
    chk("rst_ready", bus_if.stepperReady, 1);
    chk("rst_busy",  bus_if.busy, 0);
    chk("rst_step1", bus_if.step1_out, 0);
    chk("rst_dir1",  bus_if.dir1_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: steps 3/1, dirs 1/0, full cycle-by-cycle trace
    b1 = c1; b2 = c2;
    start_load(8'd3, 8'd1, 1'b1, 1'b0, 1'b0);
    tr1 = '0; tr2 = '0; trr = '0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      tr1[i] = bus_if.step1_out;
      tr2[i] = bus_if.step2_out;
      trr[i] = bus_if.stepperReady;
      if (i == 0) begin
        chk("t1_dir1", bus_if.dir1_out, 1);
        chk("t1_dir2", bus_if.dir2_out, 0);
        chk("t1_busy", bus_if.busy, 1);
      end
    end
    chk("t1_step1_trace", tr1, 25368);
    chk("t1_step2_trace", tr2, 24);
    chk("t1_ready_trace", trr, 262144);
    chk("t1_pulses1", c1 - b1, 3);
    chk("t1_pulses2", c2 - b2, 1);

    // 2: zero-step move
    b1 = c1; b2 = c2;
    start_load(8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_idle(50, low);
    chk("t2_low_cycles", low, 3);
    chk("t2_pulses1", c1 - b1, 0);
    chk("t2_pulses2", c2 - b2, 0);
    chk("t2_dir2", bus_if.dir2_out, 1);

    // halt in IDLE, same cycle as an edge, then a held level: no load either time
    @(negedge clk);
    bus_if.steps1    = 8'd2;
    bus_if.halt      = 1'b1;
    bus_if.dataReady = 1'b1;
    @(negedge clk);
    chk("halt_idle_ready", bus_if.stepperReady, 1);
    bus_if.halt = 1'b0;
    @(negedge clk);
    chk("held_level_ready", bus_if.stepperReady, 1);
    bus_if.dataReady = 1'b0;

    // 3: second edge mid-move is ignored
    b1 = c1; b2 = c2;
    start_load(8'd5, 8'd0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    bus_if.steps1    = 8'd7;
    bus_if.dir1      = 1'b0;
    bus_if.dir2      = 1'b0;
    bus_if.dataReady = 1'b1;
    @(negedge clk);
    bus_if.dataReady = 1'b0;
    wait_idle(100, low);
    chk("t3_low_rest", low, 17);
    chk("t3_pulses1", c1 - b1, 5);
    chk("t3_pulses2", c2 - b2, 0);
    chk("t3_dir1", bus_if.dir1_out, 1);
    chk("t3_dir2", bus_if.dir2_out, 1);
    repeat (3) @(negedge clk);
    chk("t3_no_queue", bus_if.stepperReady, 1);

    // 4: halt during the second HIGH phase
    b1 = c1;
    start_load(8'd4, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    chk("t4_step1_high", bus_if.step1_out, 1);
    bus_if.halt = 1'b1;
    @(negedge clk);
    chk("t4_step1_after", bus_if.step1_out, 0);
    chk("t4_ready_after", bus_if.stepperReady, 1);
    bus_if.halt = 1'b0;
    chk("t4_pulses1", c1 - b1, 2);
    b1 = c1; b2 = c2;
    start_load(8'd1, 8'd2, 1'b0, 1'b1, 1'b0);
    wait_idle(100, low);
    chk("t4_reload_low", low, 13);
    chk("t4_reload_p1", c1 - b1, 1);
    chk("t4_reload_p2", c2 - b2, 2);
    chk("t4_reload_dir2", bus_if.dir2_out, 1);

    // 5: asynchronous reset in the middle of a pulse
    start_load(8'd2, 8'd2, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_step1_pre", bus_if.step1_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_step1", bus_if.step1_out, 0);
    chk("t5_step2", bus_if.step2_out, 0);
    chk("t5_dir1", bus_if.dir1_out, 0);
    chk("t5_dir2", bus_if.dir2_out, 0);
    chk("t5_ready", bus_if.stepperReady, 1);
    chk("t5_busy", bus_if.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_ready_post", bus_if.stepperReady, 1);

    // 6: level held across completion, then a fresh edge with 255 steps
    b1 = c1;
    start_load(8'd1, 8'd0, 1'b0, 1'b0, 1'b1);
    wait_idle(50, low);
    chk("t6_first_low", low, 8);
    repeat (5) @(negedge clk);
    chk("t6_no_reload", bus_if.stepperReady, 1);
    chk("t6_first_pulses", c1 - b1, 1);
    bus_if.dataReady = 1'b0;
    @(negedge clk);
    b1 = c1; b2 = c2;
    start_load(8'd255, 8'd3, 1'b1, 1'b0, 1'b0);
    wait_idle(2000, low);
    chk("t6_long_low", low, 1278);
    chk("t6_long_p1", c1 - b1, 255);
    chk("t6_long_p2", c2 - b2, 3);
    chk("t6_dir1", bus_if.dir1_out, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
